im_fetch_unit: RTL and testbench

- Parametrised, synchronous successor to the combinational instruction ROM.
- Holds DEPTH instruction words, clears itself after reset, and accepts a program through a write port.
- Serves fetch requests through a valid/ready handshake with registered read, a 2-entry response buffer and address-fault reporting.
- Sits between the PC register and the decode stage of the pipelined core.

---
 rtl/im_pkg.sv | 26 ++
 rtl/im_fetch_unit_if.sv | 40 ++++
 rtl/im_resp_fifo.sv | 41 ++++
 rtl/im_fetch_unit.sv | 123 ++++++++++++
 tb/tb_im_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_pkg.sv
// Shared types for the instruction fetch unit: FSM states, fault codes and the buffered response word.
package im_pkg;
   localparam int IM_DATA_W = 32;

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_RANGE    = 2'b10;
   localparam logic [1:0] FC_BOTH     = 2'b11;

   typedef struct packed {
      logic [IM_DATA_W-1:0] instruction;
      logic                 fault;
      logic [1:0]           code;
   } resp_t;

   function automatic logic [1:0] addr_fault_code(input logic mis, input logic oor);
      case ({oor, mis})
         2'b01:   return FC_MISALIGN;
         2'b10:   return FC_RANGE;
         2'b11:   return FC_BOTH;
         default: return FC_NONE;
      endcase
   endfunction
endpackage

// File: rtl/im_fetch_unit_if.sv
// Fetch/response handshake and program-write bundle; inj_par_err exists only with IM_PARITY_EN.
interface im_fetch_unit_if #(
   parameter int PC_W   = 64,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512
);
   localparam int IDX_W = $clog2(DEPTH);

   logic              init_done;
   logic              req_valid;
   logic              req_ready;
   logic [PC_W-1:0]   busPc;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] instruction;
   logic              resp_fault;
   logic [1:0]        fault_code;
   logic              prog_we;
   logic [IDX_W-1:0]  prog_idx;
   logic [DATA_W-1:0] prog_data;
`ifdef IM_PARITY_EN
   logic              inj_par_err;
`endif

   modport master (
      input  init_done, req_ready, resp_valid, instruction, resp_fault, fault_code,
      output req_valid, busPc, resp_ready, prog_we, prog_idx, prog_data
`ifdef IM_PARITY_EN
      , output inj_par_err
`endif
   );

   modport slave (
      output init_done, req_ready, resp_valid, instruction, resp_fault, fault_code,
      input  req_valid, busPc, resp_ready, prog_we, prog_idx, prog_data
`ifdef IM_PARITY_EN
      , input inj_par_err
`endif
   );
endinterface

// File: rtl/im_resp_fifo.sv
// Two-entry first-word-fall-through response buffer; head is valid whenever cnt_o != 0.
module im_resp_fifo
   import im_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  resp_t      dat_i,
   input  logic       pop_i,
   output resp_t      dat_o,
   output logic [1:0] cnt_o
);
   resp_t      ent_q [2];
   logic       wr_q;
   logic       rd_q;
   logic [1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_i) begin
            ent_q[wr_q] <= dat_i;
            wr_q        <= ~wr_q;
         end
         if (pop_i) rd_q <= ~rd_q;
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign dat_o = ent_q[rd_q];
   assign cnt_o = cnt_q;
endmodule

// File: rtl/im_fetch_unit.sv
// Self-clearing DEPTH-word instruction memory with program port and handshaked, in-order fetch.
// IM_PARITY_EN adds a stored even-parity bit per word and the inj_par_err test input.
module im_fetch_unit
   import im_pkg::*;
#(
   parameter int PC_W   = 64,
   parameter int DATA_W = IM_DATA_W,
   parameter int DEPTH  = 512
) (
   input logic            clk,
   input logic            reset,
   im_fetch_unit_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);

   state_t            state_q;
   logic [IDX_W-1:0]  clr_idx_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_dat_q;
   logic              rd_vld_q;
   logic              rd_afault_q;
   logic [1:0]        rd_code_q;
   resp_t             rd_resp, head, cur, out, last_q;
   logic [1:0]        fifo_cnt, occ;
   logic              run, accept, rd_en, mis, oor, push, pop, resp_vld, par_err;
   logic [IDX_W-1:0]  idx;

   assign run = (state_q == RUN);
   assign idx = bus.busPc[IDX_W+1:2];
   assign mis = |bus.busPc[1:0];
   assign oor = |bus.busPc[PC_W-1:IDX_W+2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= INIT;
         clr_idx_q <= '0;
      end else if (state_q == INIT) begin
         clr_idx_q <= clr_idx_q + 1'b1;
         if (clr_idx_q == IDX_W'(DEPTH - 1)) state_q <= RUN;
      end
   end

   // Array has no reset: INIT sweeps it to zero; the read sees pre-write data.
   always_ff @(posedge clk) begin
      if (!run) mem[clr_idx_q] <= '0;
      else if (bus.prog_we) mem[bus.prog_idx] <= bus.prog_data;
      if (rd_en) rd_dat_q <= mem[idx];
   end

`ifdef IM_PARITY_EN
   logic par_mem [DEPTH];
   logic rd_par_q;

   always_ff @(posedge clk) begin
      if (!run) par_mem[clr_idx_q] <= 1'b0;
      else if (bus.prog_we) par_mem[bus.prog_idx] <= (^bus.prog_data) ^ bus.inj_par_err;
      if (rd_en) rd_par_q <= par_mem[idx];
   end

   assign par_err = (^rd_dat_q) != rd_par_q;
`else
   assign par_err = 1'b0;
`endif

   assign rd_en  = accept && !(mis || oor);
   assign accept = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_vld_q    <= 1'b0;
         rd_afault_q <= 1'b0;
         rd_code_q   <= FC_NONE;
         last_q      <= '0;
      end else begin
         rd_vld_q <= accept;
         if (accept) begin
            rd_afault_q <= mis || oor;
            rd_code_q   <= addr_fault_code(mis, oor);
         end
         if (resp_vld) last_q <= cur;
      end
   end

   always_comb begin
      rd_resp.instruction = rd_dat_q;
      rd_resp.fault       = 1'b0;
      rd_resp.code        = FC_NONE;
      if (rd_afault_q) begin
         rd_resp.instruction = '0;
         rd_resp.fault       = 1'b1;
         rd_resp.code        = rd_code_q;
      end else if (par_err) begin
         rd_resp.fault = 1'b1;
         rd_resp.code  = FC_BOTH;
      end
   end

   // An empty buffer lets the in-flight read go straight out; otherwise it queues behind.
   assign push = rd_vld_q && !(fifo_cnt == 2'd0 && bus.resp_ready);
   assign pop  = (fifo_cnt != 2'd0) && bus.resp_ready;

   im_resp_fifo u_resp_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (push),
      .dat_i  (rd_resp),
      .pop_i  (pop),
      .dat_o  (head),
      .cnt_o  (fifo_cnt)
   );

   assign resp_vld = (fifo_cnt != 2'd0) || rd_vld_q;
   assign cur      = (fifo_cnt != 2'd0) ? head : rd_resp;
   assign out      = resp_vld ? cur : last_q;
   assign occ      = fifo_cnt + {1'b0, rd_vld_q};

   assign bus.init_done   = run;
   assign bus.req_ready   = run && ((occ < 2'd2) || (resp_vld && bus.resp_ready));
   assign bus.resp_valid  = resp_vld;
   assign bus.instruction = out.instruction;
   assign bus.resp_fault  = out.fault;
   assign bus.fault_code  = out.code;
endmodule

// File: tb/tb_im_fetch_unit.sv
// Directed bench for im_fetch_unit: init timing, fetch, back-pressure, faults, collision, mid-run reset.
module tb_im_fetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   im_fetch_unit_if bus ();

   im_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog_word(input int idx, input logic [31:0] d);
      bus.prog_we   = 1'b1;
      bus.prog_idx  = 9'(idx);
      bus.prog_data = d;
      step();
      bus.prog_we   = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++;
      if ({bus.init_done, bus.req_ready, bus.resp_valid, bus.resp_fault, bus.fault_code} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {bus.init_done, bus.req_ready, bus.resp_valid, bus.resp_fault, bus.fault_code});
      end
      checks++;
      if (bus.instruction !== 32'h0) begin
         errors++;
         $display("FAIL reset_instr: got %h expected 00000000", bus.instruction);
      end
   endtask

   task automatic test_init();
      int n = 0;
      bit early = 1'b0;
      bus.req_valid  = 1'b1;
      bus.busPc      = 64'h0;
      bus.resp_ready = 1'b1;
      reset = 1'b0;
      while (!bus.init_done && n < 600) begin
         if (bus.req_ready) early = 1'b1;
         step();
         n++;
      end
      checks++;
      if (n != 512) begin
         errors++;
         $display("FAIL init_cycles: got %0d expected 512", n);
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL init_req_ready: got 1 during INIT expected 0");
      end
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL held_req_ready: got %b expected 1", bus.req_ready);
      end
      step();
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.resp_valid, bus.resp_fault, bus.instruction} !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL held_req_resp: got v=%b f=%b %h expected v=1 f=0 00000000",
                  bus.resp_valid, bus.resp_fault, bus.instruction);
      end
      step();
      checks++;
      if (bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL held_req_drain: got %b expected 0", bus.resp_valid);
      end
   endtask

   task automatic test_program_fetch();
      logic [63:0] pcs [3];
      logic [31:0] exp_w [3];
      pcs   = '{64'd0, 64'd4, 64'd24};
      exp_w = '{32'hF84002A0, 32'hF84002A1, 32'h17FFFFFE};
      prog_word(0, 32'hF84002A0);
      prog_word(1, 32'hF84002A1);
      prog_word(6, 32'h17FFFFFE);
      bus.resp_ready = 1'b1;
      bus.req_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.busPc = pcs[i];
         #1;
         checks++;
         if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d: got %b expected 1", i, bus.req_ready);
         end
         step();
         checks++;
         if ({bus.resp_valid, bus.resp_fault, bus.instruction} !== {2'b10, exp_w[i]}) begin
            errors++;
            $display("FAIL b2b_resp%0d: got v=%b f=%b %h expected v=1 f=0 %h",
                     i, bus.resp_valid, bus.resp_fault, bus.instruction, exp_w[i]);
         end
      end
      bus.req_valid = 1'b0;
      step();
      checks++;
      if ({bus.resp_valid, bus.instruction} !== {1'b0, 32'h17FFFFFE}) begin
         errors++;
         $display("FAIL b2b_idle_hold: got v=%b %h expected v=0 17fffffe", bus.resp_valid, bus.instruction);
      end
   endtask

   task automatic test_backpressure();
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.busPc      = 64'd0;
      step();
      bus.busPc = 64'd4;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second_ready: got %b expected 1", bus.req_ready);
      end
      step();
      bus.busPc = 64'd24;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.req_ready, bus.resp_valid, bus.instruction} !== {2'b01, 32'hF84002A0}) begin
            errors++;
            $display("FAIL bp_hold%0d: got rdy=%b v=%b %h expected rdy=0 v=1 f84002a0",
                     i, bus.req_ready, bus.resp_valid, bus.instruction);
         end
         step();
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      step();
      checks++;
      if ({bus.resp_valid, bus.instruction} !== {1'b1, 32'hF84002A1}) begin
         errors++;
         $display("FAIL bp_drain2: got v=%b %h expected v=1 f84002a1", bus.resp_valid, bus.instruction);
      end
      step();
      checks++;
      if (bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drained: got %b expected 0", bus.resp_valid);
      end
   endtask

   task automatic test_faults();
      logic [63:0] pcs [4];
      logic [2:0]  exp_f [4];
      logic [31:0] exp_w [4];
      pcs   = '{64'h6, 64'h800, 64'h802, 64'h7FC};
      exp_f = '{3'b101, 3'b110, 3'b111, 3'b000};
      exp_w = '{32'h0, 32'h0, 32'h0, 32'h13579BDF};
      prog_word(511, 32'h13579BDF);
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 1'b1;
         bus.busPc     = pcs[i];
         step();
         bus.req_valid = 1'b0;
         checks++;
         if ({bus.resp_valid, bus.resp_fault, bus.fault_code, bus.instruction} !== {1'b1, exp_f[i], exp_w[i]}) begin
            errors++;
            $display("FAIL fault_pc%h: got v=%b f=%b c=%b %h expected v=1 f=%b c=%b %h",
                     pcs[i], bus.resp_valid, bus.resp_fault, bus.fault_code, bus.instruction,
                     exp_f[i][2], exp_f[i][1:0], exp_w[i]);
         end
         step();
      end
   endtask

   task automatic test_collision();
      prog_word(3, 32'h8B000023);
      bus.resp_ready = 1'b1;
      bus.prog_we    = 1'b1;
      bus.prog_idx   = 9'd3;
      bus.prog_data  = 32'hB4000042;
      bus.req_valid  = 1'b1;
      bus.busPc      = 64'hC;
      step();
      bus.prog_we   = 1'b0;
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.resp_valid, bus.instruction} !== {1'b1, 32'h8B000023}) begin
         errors++;
         $display("FAIL collide_old: got v=%b %h expected v=1 8b000023", bus.resp_valid, bus.instruction);
      end
      step();
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.resp_valid, bus.instruction} !== {1'b1, 32'hB4000042}) begin
         errors++;
         $display("FAIL collide_new: got v=%b %h expected v=1 b4000042", bus.resp_valid, bus.instruction);
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic [63:0] pcs [3];
      int n = 0;
      pcs = '{64'h0, 64'hC, 64'h18};
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.busPc      = 64'h0;
      step();
      bus.busPc = 64'h4;
      step();
      bus.req_valid = 1'b0;
      step();
      checks++;
      if ({bus.resp_valid, bus.req_ready, bus.instruction} !== {2'b10, 32'hF84002A0}) begin
         errors++;
         $display("FAIL mid_buffered: got v=%b rdy=%b %h expected v=1 rdy=0 f84002a0",
                  bus.resp_valid, bus.req_ready, bus.instruction);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.resp_valid, bus.req_ready, bus.init_done, bus.resp_fault, bus.fault_code, bus.instruction} !== 38'h0) begin
         errors++;
         $display("FAIL mid_reset_outs: got v=%b rdy=%b done=%b f=%b c=%b %h expected all zero",
                  bus.resp_valid, bus.req_ready, bus.init_done, bus.resp_fault, bus.fault_code, bus.instruction);
      end
      step();
      step();
      reset = 1'b0;
      bus.resp_ready = 1'b1;
      while (!bus.init_done && n < 600) begin
         step();
         n++;
      end
      checks++;
      if (n != 512) begin
         errors++;
         $display("FAIL mid_reinit_cycles: got %0d expected 512", n);
      end
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1'b1;
         bus.busPc     = pcs[i];
         step();
         bus.req_valid = 1'b0;
         checks++;
         if ({bus.resp_valid, bus.resp_fault, bus.instruction} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL mid_cleared%0d: got v=%b f=%b %h expected v=1 f=0 00000000",
                     i, bus.resp_valid, bus.resp_fault, bus.instruction);
         end
         step();
      end
`ifdef IM_PARITY_EN
      bus.inj_par_err = 1'b1;
      prog_word(5, 32'h000000FF);
      bus.inj_par_err = 1'b0;
      bus.req_valid = 1'b1;
      bus.busPc     = 64'h14;
      step();
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.resp_valid, bus.resp_fault, bus.fault_code} !== 4'b1111) begin
         errors++;
         $display("FAIL parity_inject: got v=%b f=%b c=%b expected v=1 f=1 c=11",
                  bus.resp_valid, bus.resp_fault, bus.fault_code);
      end
      step();
`endif
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.busPc      = '0;
      bus.resp_ready = 1'b0;
      bus.prog_we    = 1'b0;
      bus.prog_idx   = '0;
      bus.prog_data  = '0;
`ifdef IM_PARITY_EN
      bus.inj_par_err = 1'b0;
`endif
      test_reset();
      test_init();
      test_program_fetch();
      test_backpressure();
      test_faults();
      test_collision();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
